nwide_fwd_scoreboard: RTL and testbench

//  Parametrised forwarding/interlock unit for the W-wide in-order pipeline (F/D/X/M/W).

---
 rtl/nwide_fwd_scoreboard_pkg.sv | 26 ++
 rtl/nwide_fwd_scoreboard_fwd_src_match.sv | 36 +++
 rtl/nwide_fwd_scoreboard.sv | 171 +++++++++++++++++
 tb/tb_nwide_fwd_scoreboard.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nwide_fwd_scoreboard_pkg.sv
// Shared forwarding-select encodings and update-mode type for the
// W-wide forwarding/interlock scoreboard and the X-stage operand mux decode.
package nwide_fwd_scoreboard_pkg;

   localparam int unsigned REGW   = 5;
   localparam int unsigned SEL_RF = 0;

   // Operand taken from MW latch lane k
   function automatic int unsigned sel_mw(input int unsigned k);
      return 1 + k;
   endfunction

   // Operand taken from XM latch lane k of a w-wide pipeline
   function automatic int unsigned sel_xm(input int unsigned w, input int unsigned k);
      return 1 + w + k;
   endfunction

   // Which update rule the shadow registers follow this cycle
   typedef enum logic [1:0] {
      UPD_RESET,
      UPD_FREEZE,
      UPD_FLUSH,
      UPD_ADVANCE
   } upd_e;

endpackage

// File: rtl/nwide_fwd_scoreboard_fwd_src_match.sv
// Prioritised bypass select for one source operand against the XM and MW
// shadow entries: XM beats MW, and within a stage the higher lane wins.
module fwd_src_match #(
   parameter int unsigned W    = 2,
   parameter int unsigned REGW = nwide_fwd_scoreboard_pkg::REGW,
   parameter int unsigned SELW = 3
) (
   input  logic [REGW-1:0]   src,
   input  logic              use_src,
   input  logic [W-1:0]      xm_valid,
   input  logic [W-1:0]      xm_write,
   input  logic [W*REGW-1:0] xm_rd,
   input  logic [W-1:0]      mw_valid,
   input  logic [W-1:0]      mw_write,
   input  logic [W*REGW-1:0] mw_rd,
   output logic [SELW-1:0]   sel
);
   import nwide_fwd_scoreboard_pkg::*;

   // Later assignments override earlier ones, so scanning MW then XM in
   // ascending lane order leaves the youngest, closest producer selected.
   always_comb begin
      sel = SELW'(SEL_RF);
      if (use_src && src != '0) begin
         for (int unsigned k = 0; k < W; k++) begin
            if (mw_valid[k] && mw_write[k] && mw_rd[k*REGW +: REGW] == src)
               sel = SELW'(sel_mw(k));
         end
         for (int unsigned k = 0; k < W; k++) begin
            if (xm_valid[k] && xm_write[k] && xm_rd[k*REGW +: REGW] == src)
               sel = SELW'(sel_xm(W, k));
         end
      end
   end

endmodule

// File: rtl/nwide_fwd_scoreboard.sv
// Forwarding/interlock scoreboard for a W-wide in-order pipeline: shadow
// DX/XM/MW destination tags, per-lane bypass selects, load-use stall,
// intra-bundle RAW split issue and a saturating stall-cycle counter.
module nwide_fwd_scoreboard #(
   parameter int unsigned W    = 2,
   parameter int unsigned REGW = nwide_fwd_scoreboard_pkg::REGW,
   parameter int unsigned SELW = 3,
   parameter int unsigned CNTW = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [W-1:0]      id_valid,
   input  logic [W*REGW-1:0] id_rs,
   input  logic [W*REGW-1:0] id_rt,
   input  logic [W-1:0]      id_use_rs,
   input  logic [W-1:0]      id_use_rt,
   input  logic [W*REGW-1:0] id_rd,
   input  logic [W-1:0]      id_regWrite,
   input  logic [W-1:0]      id_memToReg,
   input  logic              mem_ready,
   input  logic              flush,
   output logic [W*SELW-1:0] fwd_a,
   output logic [W*SELW-1:0] fwd_b,
   output logic [W-1:0]      issue_mask,
   output logic              id_hold,
   output logic [CNTW-1:0]   stall_cnt
);
   import nwide_fwd_scoreboard_pkg::*;

   logic [W-1:0]      dx_valid, dx_write, dx_load, dx_use_rs, dx_use_rt;
   logic [W*REGW-1:0] dx_rd, dx_rs, dx_rt;
   logic [W-1:0]      xm_valid, xm_write;
   logic [W*REGW-1:0] xm_rd;
   logic [W-1:0]      mw_valid, mw_write;
   logic [W*REGW-1:0] mw_rd;
   logic [W-1:0]      issued_mask;

   logic [W-1:0]      pending, can_issue;
   logic              load_stall, split_found, raw;
   upd_e              upd;

   function automatic logic reads(input logic [REGW-1:0] r, rs, rt,
                                  input logic urs, urt);
      return (r != '0) && ((urs && rs == r) || (urt && rt == r));
   endfunction

   // Load-use and intra-bundle RAW detection over the still-unissued lanes
   always_comb begin
      pending     = id_valid & ~issued_mask;
      load_stall  = 1'b0;
      split_found = 1'b0;
      raw         = 1'b0;
      can_issue   = '0;
      for (int unsigned j = 0; j < W; j++) begin
         for (int unsigned i = 0; i < W; i++) begin
            if (pending[j] && dx_valid[i] && dx_write[i] && dx_load[i] &&
                reads(dx_rd[i*REGW +: REGW], id_rs[j*REGW +: REGW], id_rt[j*REGW +: REGW],
                      id_use_rs[j], id_use_rt[j]))
               load_stall = 1'b1;
         end
      end
      for (int unsigned j = 0; j < W; j++) begin
         raw = 1'b0;
         for (int unsigned i = 0; i < j; i++) begin
            if (pending[i] && id_regWrite[i] &&
                reads(id_rd[i*REGW +: REGW], id_rs[j*REGW +: REGW], id_rt[j*REGW +: REGW],
                      id_use_rs[j], id_use_rt[j]))
               raw = 1'b1;
         end
         if (pending[j] && raw)
            split_found = 1'b1;
         if (!split_found)
            can_issue[j] = pending[j];
      end
   end

   // Update-mode priority and the decode-side handshake outputs
   always_comb begin
      if (reset)           upd = UPD_RESET;
      else if (!mem_ready) upd = UPD_FREEZE;
      else if (flush)      upd = UPD_FLUSH;
      else                 upd = UPD_ADVANCE;
      issue_mask = (upd == UPD_ADVANCE && !load_stall) ? can_issue : '0;
      id_hold    = (upd == UPD_FREEZE || upd == UPD_ADVANCE) &&
                   (load_stall || (pending & ~can_issue) != '0);
   end

   // Shadow latch, issued-lane and stall-counter state
   always_ff @(posedge clock) begin
      case (upd)
         UPD_RESET: begin
            dx_valid    <= '0;
            dx_write    <= '0;
            dx_load     <= '0;
            dx_use_rs   <= '0;
            dx_use_rt   <= '0;
            dx_rd       <= '0;
            dx_rs       <= '0;
            dx_rt       <= '0;
            xm_valid    <= '0;
            xm_write    <= '0;
            xm_rd       <= '0;
            mw_valid    <= '0;
            mw_write    <= '0;
            mw_rd       <= '0;
            issued_mask <= '0;
            stall_cnt   <= '0;
         end
         UPD_FREEZE: begin
         end
         UPD_FLUSH: begin
            mw_valid    <= xm_valid;
            mw_write    <= xm_write;
            mw_rd       <= xm_rd;
            xm_valid    <= '0;
            dx_valid    <= '0;
            issued_mask <= '0;
         end
         UPD_ADVANCE: begin
            mw_valid  <= xm_valid;
            mw_write  <= xm_write;
            mw_rd     <= xm_rd;
            xm_valid  <= dx_valid;
            xm_write  <= dx_write;
            xm_rd     <= dx_rd;
            dx_valid  <= issue_mask;
            dx_write  <= id_regWrite;
            dx_load   <= id_memToReg;
            dx_use_rs <= id_use_rs;
            dx_use_rt <= id_use_rt;
            dx_rd     <= id_rd;
            dx_rs     <= id_rs;
            dx_rt     <= id_rt;
            // A load-use bubble leaves any partial split progress untouched
            if (!load_stall)
               issued_mask <= id_hold ? (issued_mask | issue_mask) : '0;
            if (id_hold && stall_cnt != '1)
               stall_cnt <= stall_cnt + 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Two bypass-select units per lane, one per DX operand
   for (genvar k = 0; k < W; k++) begin : g_lane
      fwd_src_match #(.W(W), .REGW(REGW), .SELW(SELW)) u_sel_a (
         .src      (dx_rs[k*REGW +: REGW]),
         .use_src  (dx_valid[k] & dx_use_rs[k]),
         .xm_valid (xm_valid),
         .xm_write (xm_write),
         .xm_rd    (xm_rd),
         .mw_valid (mw_valid),
         .mw_write (mw_write),
         .mw_rd    (mw_rd),
         .sel      (fwd_a[k*SELW +: SELW])
      );
      fwd_src_match #(.W(W), .REGW(REGW), .SELW(SELW)) u_sel_b (
         .src      (dx_rt[k*REGW +: REGW]),
         .use_src  (dx_valid[k] & dx_use_rt[k]),
         .xm_valid (xm_valid),
         .xm_write (xm_write),
         .xm_rd    (xm_rd),
         .mw_valid (mw_valid),
         .mw_write (mw_write),
         .mw_rd    (mw_rd),
         .sel      (fwd_b[k*SELW +: SELW])
      );
   end

endmodule

// File: tb/tb_nwide_fwd_scoreboard.sv
// Self-checking bench for nwide_fwd_scoreboard (W=2, 4-bit stall counter):
// directed hazard scenarios followed by random bundles, all checked against
// an instruction-level pipeline model.
module tb_nwide_fwd_scoreboard;

   localparam int unsigned W    = 2;
   localparam int unsigned REGW = 5;
   localparam int unsigned SELW = 3;
   localparam int unsigned CNTW = 4;

   typedef struct {
      logic            v, wr, ld, urs, urt;
      logic [REGW-1:0] rd, rs, rt;
   } instr_t;

   logic              clock = 1'b0;
   logic              reset, mem_ready, flush;
   logic [W-1:0]      id_valid, id_use_rs, id_use_rt, id_regWrite, id_memToReg;
   logic [W*REGW-1:0] id_rs, id_rt, id_rd;
   logic [W*SELW-1:0] fwd_a, fwd_b;
   logic [W-1:0]      issue_mask;
   logic              id_hold;
   logic [CNTW-1:0]   stall_cnt;

   always #5 clock = ~clock;

   nwide_fwd_scoreboard #(.W(W), .REGW(REGW), .SELW(SELW), .CNTW(CNTW)) dut (
      .clock       (clock),
      .reset       (reset),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_use_rs   (id_use_rs),
      .id_use_rt   (id_use_rt),
      .id_rd       (id_rd),
      .id_regWrite (id_regWrite),
      .id_memToReg (id_memToReg),
      .mem_ready   (mem_ready),
      .flush       (flush),
      .fwd_a       (fwd_a),
      .fwd_b       (fwd_b),
      .issue_mask  (issue_mask),
      .id_hold     (id_hold),
      .stall_cnt   (stall_cnt)
   );

   // Model state: instructions sitting in each latch
   instr_t      dec[W], dx[W], xm[W], mw[W];
   logic [W-1:0] issued;
   int unsigned  cnt;
   logic [W-1:0] e_issue, e_can;
   logic         e_hold, e_ls;
   int unsigned  n_checks = 0;
   int unsigned  n_fail   = 0;

   function automatic instr_t mk(input logic v, wr, ld, input logic [REGW-1:0] rd,
                                 input logic urs, input logic [REGW-1:0] rs,
                                 input logic urt, input logic [REGW-1:0] rt);
      instr_t t;
      t.v = v; t.wr = wr; t.ld = ld; t.rd = rd;
      t.urs = urs; t.rs = rs; t.urt = urt; t.rt = rt;
      return t;
   endfunction

   function automatic instr_t bub();
      return mk(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
   endfunction

   function automatic instr_t nop();
      return mk(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
   endfunction

   function automatic instr_t rnd();
      instr_t t;
      t.v   = $urandom_range(0, 9) < 8;
      t.wr  = $urandom_range(0, 1) == 1;
      t.ld  = t.wr && ($urandom_range(0, 2) == 0);
      t.rd  = REGW'($urandom_range(0, 3));
      t.urs = $urandom_range(0, 1) == 1;
      t.rs  = REGW'($urandom_range(0, 3));
      t.urt = $urandom_range(0, 1) == 1;
      t.rt  = REGW'($urandom_range(0, 3));
      return t;
   endfunction

   function automatic logic reads(input instr_t d, input logic [REGW-1:0] r);
      return (r != 0) && ((d.urs && d.rs == r) || (d.urt && d.rt == r));
   endfunction

   // Youngest producer wins: search XM from the top lane, then MW
   function automatic int unsigned exp_sel(input logic [REGW-1:0] src, input logic u);
      if (!u || src == 0) return 0;
      for (int k = W - 1; k >= 0; k--)
         if (xm[k].v && xm[k].wr && xm[k].rd == src) return 1 + W + k;
      for (int k = W - 1; k >= 0; k--)
         if (mw[k].v && mw[k].wr && mw[k].rd == src) return 1 + k;
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int k = 0; k < W; k++) begin
         id_valid[k]               = dec[k].v;
         id_regWrite[k]            = dec[k].wr;
         id_memToReg[k]            = dec[k].ld;
         id_use_rs[k]              = dec[k].urs;
         id_use_rt[k]              = dec[k].urt;
         id_rd[k*REGW +: REGW]     = dec[k].rd;
         id_rs[k*REGW +: REGW]     = dec[k].rs;
         id_rt[k*REGW +: REGW]     = dec[k].rt;
      end
   endtask

   task automatic predict();
      logic [W-1:0] pend;
      int unsigned  first;
      for (int k = 0; k < W; k++) pend[k] = dec[k].v && !issued[k];
      e_ls = 1'b0;
      for (int j = 0; j < W; j++)
         for (int i = 0; i < W; i++)
            if (pend[j] && dx[i].v && dx[i].wr && dx[i].ld && reads(dec[j], dx[i].rd))
               e_ls = 1'b1;
      first = W;
      for (int j = 0; j < W; j++)
         for (int i = 0; i < j; i++)
            if (first == W && pend[j] && pend[i] && dec[i].wr && reads(dec[j], dec[i].rd))
               first = j;
      e_can   = pend & W'((1 << first) - 1);
      e_issue = (reset || !mem_ready || flush || e_ls) ? '0 : e_can;
      e_hold  = !reset && !flush && (e_ls || (pend & ~e_can) != 0);
   endtask

   // Apply inputs, let them settle, compare every output with the model
   task automatic settle();
      drive();
      #3;
      predict();
      for (int k = 0; k < W; k++) begin
         chk($sformatf("fwd_a[%0d]", k), 32'(fwd_a[k*SELW +: SELW]), exp_sel(dx[k].rs, dx[k].v && dx[k].urs));
         chk($sformatf("fwd_b[%0d]", k), 32'(fwd_b[k*SELW +: SELW]), exp_sel(dx[k].rt, dx[k].v && dx[k].urt));
      end
      chk("issue_mask", 32'(issue_mask), 32'(e_issue));
      chk("id_hold", 32'(id_hold), 32'(e_hold));
      chk("stall_cnt", 32'(stall_cnt), cnt);
   endtask

   // Advance the model across the clock edge
   task automatic clk();
      if (reset) begin
         for (int k = 0; k < W; k++) begin dx[k] = bub(); xm[k] = bub(); mw[k] = bub(); end
         issued = '0;
         cnt    = 0;
      end else if (!mem_ready) begin
      end else if (flush) begin
         mw = xm;
         for (int k = 0; k < W; k++) begin xm[k].v = 1'b0; dx[k].v = 1'b0; end
         issued = '0;
      end else begin
         if (e_hold && cnt < (1 << CNTW) - 1) cnt++;
         mw = xm;
         xm = dx;
         for (int k = 0; k < W; k++) begin dx[k] = dec[k]; dx[k].v = e_issue[k]; end
         if (!e_ls) issued = e_hold ? (issued | e_issue) : '0;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic cycle();
      settle();
      clk();
   endtask

   task automatic bubbles();
      for (int k = 0; k < W; k++) dec[k] = bub();
   endtask

   initial begin
      logic adv;
      reset = 1'b1; mem_ready = 1'b1; flush = 1'b0;
      for (int k = 0; k < W; k++) begin dx[k] = bub(); xm[k] = bub(); mw[k] = bub(); end
      issued = '0; cnt = 0;
      bubbles();
      drive();
      @(posedge clock); #1;
      cycle();
      reset = 1'b0;
      settle();
      chk("rst issue_mask", 32'(issue_mask), 0);
      chk("rst id_hold", 32'(id_hold), 0);
      chk("rst stall_cnt", 32'(stall_cnt), 0);
      clk();

      // XM lane1 and MW lane0 both write r5; XM lane1 must win
      dec[0] = mk(1, 1, 0, 5, 0, 0, 0, 0); dec[1] = nop(); cycle();
      dec[0] = nop(); dec[1] = mk(1, 1, 0, 5, 0, 0, 0, 0); cycle();
      dec[0] = mk(1, 1, 0, 9, 1, 5, 0, 0); dec[1] = bub(); cycle();
      bubbles(); settle();
      chk("t1 fwd_a lane0", 32'(fwd_a[0 +: SELW]), 4);
      clk();

      // Load-use: one bubble, then both lanes issue and r7 comes from MW lane0
      dec[0] = mk(1, 1, 1, 7, 0, 0, 0, 0); dec[1] = nop(); cycle();
      dec[0] = nop(); dec[1] = mk(1, 1, 0, 10, 0, 0, 1, 7); settle();
      chk("t2 stall issue", 32'(issue_mask), 0);
      chk("t2 stall hold", 32'(id_hold), 1);
      clk();
      settle();
      chk("t2 stall_cnt", 32'(stall_cnt), 1);
      chk("t2 issue", 32'(issue_mask), 3);
      clk();
      bubbles(); settle();
      chk("t2 fwd_b lane1", 32'(fwd_b[SELW +: SELW]), 1);
      clk();

      // Intra-bundle RAW on r3: split over two cycles
      dec[0] = mk(1, 1, 0, 3, 0, 0, 0, 0); dec[1] = mk(1, 1, 0, 11, 1, 3, 0, 0); settle();
      chk("t3 c0 issue", 32'(issue_mask), 1);
      chk("t3 c0 hold", 32'(id_hold), 1);
      clk();
      settle();
      chk("t3 c1 issue", 32'(issue_mask), 2);
      chk("t3 c1 hold", 32'(id_hold), 0);
      clk();
      bubbles(); settle();
      chk("t3 fwd_a lane1", 32'(fwd_a[SELW +: SELW]), 3);
      clk();

      // r0 is never forwarded or interlocked, even after a load
      dec[0] = mk(1, 1, 0, 0, 0, 0, 0, 0); dec[1] = mk(1, 1, 1, 0, 0, 0, 0, 0); cycle();
      dec[0] = mk(1, 1, 0, 12, 1, 0, 1, 0); dec[1] = mk(1, 0, 0, 0, 1, 0, 0, 0); settle();
      chk("t4 issue", 32'(issue_mask), 3);
      chk("t4 hold", 32'(id_hold), 0);
      clk();
      bubbles(); settle();
      chk("t4 fwd_a lane0", 32'(fwd_a[0 +: SELW]), 0);
      chk("t4 fwd_b lane0", 32'(fwd_b[0 +: SELW]), 0);
      clk();

      // Memory stall in the middle of a split freezes everything
      dec[0] = mk(1, 1, 0, 4, 0, 0, 0, 0); dec[1] = mk(1, 1, 0, 13, 0, 0, 1, 4); settle();
      chk("t5 c0 issue", 32'(issue_mask), 1);
      clk();
      mem_ready = 1'b0;
      for (int n = 0; n < 3; n++) begin
         settle();
         chk("t5 frozen issue", 32'(issue_mask), 0);
         chk("t5 frozen cnt", 32'(stall_cnt), 3);
         clk();
      end
      mem_ready = 1'b1;
      settle();
      chk("t5 resume issue", 32'(issue_mask), 2);
      chk("t5 resume hold", 32'(id_hold), 0);
      clk();

      // Flush during a load-use stall
      dec[0] = mk(1, 1, 1, 8, 0, 0, 0, 0); dec[1] = nop(); cycle();
      dec[0] = mk(1, 1, 0, 14, 1, 8, 0, 0); dec[1] = nop(); flush = 1'b1; settle();
      chk("t6 flush issue", 32'(issue_mask), 0);
      chk("t6 flush hold", 32'(id_hold), 0);
      clk();
      flush = 1'b0;
      settle();
      chk("t6 post-flush issue", 32'(issue_mask), 3);
      clk();

      // Reset in the middle of a split
      dec[0] = mk(1, 1, 0, 6, 0, 0, 0, 0); dec[1] = mk(1, 1, 0, 15, 1, 6, 0, 0); settle();
      chk("t7 c0 issue", 32'(issue_mask), 1);
      clk();
      reset = 1'b1; bubbles(); cycle();
      reset = 1'b0; settle();
      chk("t7 post-rst issue", 32'(issue_mask), 0);
      chk("t7 post-rst hold", 32'(id_hold), 0);
      chk("t7 post-rst cnt", 32'(stall_cnt), 0);
      chk("t7 post-rst fwd_a", 32'(fwd_a), 0);
      chk("t7 post-rst fwd_b", 32'(fwd_b), 0);
      clk();

      // Random bundles; F/D keeps the bundle while it is held
      adv = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if (adv) for (int k = 0; k < W; k++) dec[k] = rnd();
         mem_ready = $urandom_range(0, 99) < 85;
         flush     = $urandom_range(0, 99) < 5;
         settle();
         adv = mem_ready && (flush || !e_hold);
         clk();
      end

      // Enough load-use bubbles to drive the counter into saturation
      mem_ready = 1'b1; flush = 1'b0;
      bubbles(); cycle(); cycle();
      for (int n = 0; n < 20; n++) begin
         dec[0] = mk(1, 1, 1, 9, 0, 0, 0, 0); dec[1] = nop(); cycle();
         dec[0] = mk(1, 1, 0, 10, 1, 9, 0, 0); dec[1] = nop(); cycle(); cycle();
      end
      bubbles(); settle();
      chk("sat stall_cnt", 32'(stall_cnt), 15);
      clk();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
